// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM-state definitions for alu_seq and the decode stage.
// Opcodes at or above 15 are reserved. ALU_OP_MUL is only meaningful when ALU_MUL_EN is defined.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_NOT  = 4'd5,
    ALU_OP_SHL  = 4'd6,
    ALU_OP_SHR  = 4'd7,
    ALU_OP_SAR  = 4'd8,
    ALU_OP_ROL  = 4'd9,
    ALU_OP_ROR  = 4'd10,
    ALU_OP_INC  = 4'd11,
    ALU_OP_DEC  = 4'd12,
    ALU_OP_CMP  = 4'd13,
    ALU_OP_MUL  = 4'd14,
    ALU_OP_RSVD = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one product bit per cycle.
// Instantiated by alu_seq only when ALU_MUL_EN is defined.
module alu_mul_seq #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      start_i,
  input  logic [WORD_WIDTH-1:0]     multiplicand_i,
  input  logic [WORD_WIDTH-1:0]     multiplier_i,
  output logic                      done_o,
  output logic [2*WORD_WIDTH-1:0]   product_o
);

  localparam int unsigned CW = $clog2(WORD_WIDTH + 1);

  logic                    busy_q;
  logic [CW-1:0]           count_q;
  logic [WORD_WIDTH-1:0]   mcand_q;
  logic [2*WORD_WIDTH-1:0] acc_q;
  logic [2*WORD_WIDTH-1:0] acc_d;
  logic [WORD_WIDTH:0]     sum;

  // Accumulator holds {partial product, remaining multiplier bits}; each step adds and shifts right.
  always_comb begin
    sum   = {1'b0, acc_q[2*WORD_WIDTH-1:WORD_WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {sum, acc_q[WORD_WIDTH-1:1]};
  end

  // done_o and product_o lead the final edge so the parent captures the product on that same edge.
  assign done_o    = busy_q && (count_q == CW'(1));
  assign product_o = acc_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy_q  <= 1'b0;
      count_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      count_q <= CW'(WORD_WIDTH);
      mcand_q <= multiplicand_i;
      acc_q   <= {{WORD_WIDTH{1'b0}}, multiplier_i};
    end else if (busy_q) begin
      acc_q   <= acc_d;
      count_q <= count_q - CW'(1);
      if (count_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready handshaked ALU with registered result and carry/zero/overflow flags.
// Define ALU_MUL_EN to enable the iterative multiply on opcode 14; otherwise it behaves as reserved.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [WORD_WIDTH-1:0]   operand1,
  input  logic [WORD_WIDTH-1:0]   operand2,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [WORD_WIDTH-1:0]   result,
  output logic                    carryOut,
  output logic                    zero,
  output logic                    overflow
);

  localparam int unsigned SW  = $clog2(WORD_WIDTH);
  localparam int unsigned MSB = WORD_WIDTH - 1;
  localparam logic [WORD_WIDTH:0] EXT_ONE = (WORD_WIDTH + 1)'(1);

  alu_state_e            state_q;
  logic [WORD_WIDTH-1:0] result_q;
  logic                  carry_q, zero_q, ovf_q;

  alu_op_e               op_sel;
  logic                  accept, is_mul;
  logic [SW-1:0]         amt;
  logic [WORD_WIDTH:0]   ext;
  logic [2*WORD_WIDTH-1:0] dbl;
  logic [WORD_WIDTH-1:0] res_d;
  logic                  carry_d, ovf_d;

  assign op_sel  = (opCode < OPCODE_WIDTH'(15)) ? alu_op_e'(opCode[3:0]) : ALU_OP_RSVD;
  assign inReady = rstN && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && outReady));
  assign accept  = inValid && inReady;
  assign amt     = operand2[SW-1:0];

  // NOTE: every combinational output gets a default first so no path through the case infers a latch.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    ext     = '0;
    dbl     = '0;
    case (op_sel)
      ALU_OP_ADD: begin
        ext     = {1'b0, operand1} + {1'b0, operand2};
        res_d   = ext[WORD_WIDTH-1:0];
        carry_d = ext[WORD_WIDTH];
        ovf_d   = (operand1[MSB] == operand2[MSB]) && (res_d[MSB] != operand1[MSB]);
      end
      ALU_OP_SUB, ALU_OP_CMP: begin
        ext     = {1'b0, operand1} - {1'b0, operand2};
        res_d   = (op_sel == ALU_OP_CMP) ? operand1 : ext[WORD_WIDTH-1:0];
        carry_d = ext[WORD_WIDTH];
        ovf_d   = (operand1[MSB] != operand2[MSB]) && (ext[MSB] != operand1[MSB]);
      end
      ALU_OP_AND: res_d = operand1 & operand2;
      ALU_OP_OR:  res_d = operand1 | operand2;
      ALU_OP_XOR: res_d = operand1 ^ operand2;
      ALU_OP_NOT: res_d = ~operand1;
      // Shifts run through a guard bit so the last bit out lands in a fixed position (0 when amt == 0).
      ALU_OP_SHL: begin
        ext     = {1'b0, operand1} << amt;
        res_d   = ext[WORD_WIDTH-1:0];
        carry_d = ext[WORD_WIDTH];
      end
      ALU_OP_SHR: begin
        ext     = {operand1, 1'b0} >> amt;
        res_d   = ext[WORD_WIDTH:1];
        carry_d = ext[0];
      end
      ALU_OP_SAR: begin
        ext     = $unsigned($signed({operand1, 1'b0}) >>> amt);
        res_d   = ext[WORD_WIDTH:1];
        carry_d = ext[0];
      end
      ALU_OP_ROL: begin
        dbl     = {operand1, operand1} << amt;
        res_d   = dbl[2*WORD_WIDTH-1:WORD_WIDTH];
        carry_d = (amt != '0) && res_d[0];
      end
      ALU_OP_ROR: begin
        dbl     = {operand1, operand1} >> amt;
        res_d   = dbl[WORD_WIDTH-1:0];
        carry_d = (amt != '0) && res_d[MSB];
      end
      ALU_OP_INC: begin
        ext     = {1'b0, operand1} + EXT_ONE;
        res_d   = ext[WORD_WIDTH-1:0];
        carry_d = ext[WORD_WIDTH];
        ovf_d   = !operand1[MSB] && res_d[MSB];
      end
      ALU_OP_DEC: begin
        ext     = {1'b0, operand1} - EXT_ONE;
        res_d   = ext[WORD_WIDTH-1:0];
        carry_d = ext[WORD_WIDTH];
        ovf_d   = operand1[MSB] && !res_d[MSB];
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic                    mul_done;
  logic [2*WORD_WIDTH-1:0] mul_product;

  assign is_mul = (op_sel == ALU_OP_MUL);

  alu_mul_seq #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_mul (
    .clk           (clk),
    .rstN          (rstN),
    .start_i       (accept && is_mul),
    .multiplicand_i(operand1),
    .multiplier_i  (operand2),
    .done_o        (mul_done),
    .product_o     (mul_product)
  );
`else
  assign is_mul = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= ST_MUL;
            end else begin
              state_q  <= ST_DONE;
              result_q <= res_d;
              carry_q  <= carry_d;
              zero_q   <= (res_d == '0);
              ovf_q    <= ovf_d;
            end
          end else if (state_q == ST_DONE && outReady) begin
            state_q <= ST_IDLE;
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            state_q  <= ST_DONE;
            result_q <= mul_product[WORD_WIDTH-1:0];
            carry_q  <= |mul_product[2*WORD_WIDTH-1:WORD_WIDTH];
            zero_q   <= (mul_product[WORD_WIDTH-1:0] == '0);
            ovf_q    <= 1'b0;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign outValid = (state_q == ST_DONE);
  assign result   = result_q;
  assign carryOut = carry_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule
